// File: rtl/stream_pkg.sv
// Shared types and helpers for the streaming dot-product datapath:
// FSM state encoding, operand width helpers and the saturating accumulate.
package stream_pkg;

    // Working width for the saturating add; accumulators up to SAT_W-2 bits fit.
    localparam int SAT_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic                    sat;
        logic signed [SAT_W-1:0] value;
    } sat_result_t;

    function automatic int prod_w(input int data_w);
        return 2 * data_w;
    endfunction

    function automatic int sum_w(input int data_w, input int lanes);
        return 2 * data_w + $clog2(lanes);
    endfunction

    // Adds a beat sum into the accumulator, clamping to the signed acc_w range.
    function automatic sat_result_t sat_add(input logic signed [SAT_W-1:0] acc,
                                            input logic signed [SAT_W-1:0] sum,
                                            input int                      acc_w);
        logic signed [SAT_W:0] total;
        logic signed [SAT_W:0] max_v;
        logic signed [SAT_W:0] min_v;
        sat_result_t           res;
        total = {acc[SAT_W-1], acc} + {sum[SAT_W-1], sum};
        max_v = ({{SAT_W{1'b0}}, 1'b1} << (acc_w - 1)) - {{SAT_W{1'b0}}, 1'b1};
        min_v = ~max_v;
        if (total > max_v) begin
            res.sat   = 1'b1;
            res.value = max_v[SAT_W-1:0];
        end else if (total < min_v) begin
            res.sat   = 1'b1;
            res.value = min_v[SAT_W-1:0];
        end else begin
            res.sat   = 1'b0;
            res.value = total[SAT_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/stream_dot_product_tree.sv
// First pipeline stage: per-lane signed products registered on an accepted
// beat, followed by the combinational sign-extending adder tree.
module lane_product_tree
    import stream_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int LANES  = 4,
    localparam int PROD_W = prod_w(DATA_W),
    localparam int SUM_W  = sum_w(DATA_W, LANES)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic [LANES*DATA_W-1:0] in_a,
    input  logic [LANES*DATA_W-1:0] in_b,
    output logic                    prod_valid,
    output logic signed [SUM_W-1:0] sum
);

    logic signed [PROD_W-1:0] prod_r [LANES];
    logic                     valid_r;
    logic signed [SUM_W-1:0]  sum_s;

    // Product registers only load on a handshake so bubbles leave them untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_r <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                prod_r[i] <= '0;
            end
        end else begin
            valid_r <= en;
            if (en) begin
                for (int i = 0; i < LANES; i++) begin
                    prod_r[i] <= PROD_W'($signed(in_a[i*DATA_W +: DATA_W]))
                               * PROD_W'($signed(in_b[i*DATA_W +: DATA_W]));
                end
            end
        end
    end

    // Beat total: sign-extended lane products summed at full tree width.
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_s = sum_s + SUM_W'(prod_r[i]);
        end
    end

    assign prod_valid = valid_r;
    assign sum        = sum_s;

endmodule

// File: rtl/stream_dot_product.sv
// Multi-lane streaming dot product: counts cfg_len beats, accumulates with
// saturation and holds the result on a valid/ready output port.
module stream_dot_product
    import stream_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int ACC_W  = 24,
    parameter int LEN_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [LEN_W-1:0]        cfg_len,
    output logic                    busy,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_a,
    input  logic [LANES*DATA_W-1:0] in_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_data,
    output logic                    out_sat
);

    localparam int SUM_W = sum_w(DATA_W, LANES);

    generate
        if (ACC_W < SUM_W || ACC_W > SAT_W - 2) begin : g_bad_acc_w
            $error("stream_dot_product: ACC_W out of supported range");
        end
    endgenerate

    state_t                  state_r;
    logic [LEN_W-1:0]        len_r;
    logic [LEN_W-1:0]        cnt_r;
    logic signed [ACC_W-1:0] acc_r;
    logic                    sat_r;
    logic                    last_r;
    logic                    busy_r;
    logic                    in_ready_r;
    logic                    out_valid_r;
    logic [ACC_W-1:0]        out_data_r;
    logic                    out_sat_r;

    logic                    hs_s;
    logic                    prod_valid_s;
    logic signed [SUM_W-1:0] sum_s;
    sat_result_t             sat_res_s;
    logic signed [ACC_W-1:0] acc_next_s;
    logic                    fit_err_s;
    logic                    sat_next_s;

    assign hs_s = in_valid & in_ready_r;

    lane_product_tree #(
        .DATA_W (DATA_W),
        .LANES  (LANES)
    ) u_tree (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (hs_s),
        .in_a       (in_a),
        .in_b       (in_b),
        .prod_valid (prod_valid_s),
        .sum        (sum_s)
    );

    assign sat_res_s = sat_add({{(SAT_W-ACC_W){acc_r[ACC_W-1]}}, acc_r},
                               {{(SAT_W-SUM_W){sum_s[SUM_W-1]}}, sum_s},
                               ACC_W);
    // A clamped value that does not fit ACC_W is treated as a saturation event.
    assign fit_err_s  = |(sat_res_s.value[SAT_W-1:ACC_W-1]
                          ^ {(SAT_W-ACC_W+1){sat_res_s.value[ACC_W-1]}});
    assign acc_next_s = sat_res_s.value[ACC_W-1:0];
    assign sat_next_s = sat_res_s.sat | fit_err_s;

    // Control FSM, beat counter, accumulator and registered output port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            len_r       <= '0;
            cnt_r       <= '0;
            acc_r       <= '0;
            sat_r       <= 1'b0;
            last_r      <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_sat_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        len_r     <= cfg_len;
                        cnt_r     <= '0;
                        acc_r     <= '0;
                        sat_r     <= 1'b0;
                        last_r    <= 1'b0;
                        out_sat_r <= 1'b0;
                        busy_r    <= 1'b1;
                        if (cfg_len != '0) begin
                            state_r    <= ACCUM;
                            in_ready_r <= 1'b1;
                        end else begin
                            state_r     <= DONE;
                            out_valid_r <= 1'b1;
                            out_data_r  <= '0;
                        end
                    end
                end
                ACCUM: begin
                    if (hs_s) begin
                        cnt_r <= cnt_r + LEN_W'(1);
                        if (cnt_r == len_r - LEN_W'(1)) begin
                            in_ready_r <= 1'b0;
                            last_r     <= 1'b1;
                        end
                    end
                    // Stage 2: the beat accepted on the previous edge lands here.
                    if (prod_valid_s) begin
                        acc_r <= acc_next_s;
                        sat_r <= sat_r | sat_next_s;
                        if (last_r) begin
                            last_r      <= 1'b0;
                            out_valid_r <= 1'b1;
                            out_data_r  <= acc_next_s;
                            out_sat_r   <= sat_r | sat_next_s;
                            state_r     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_sat   = out_sat_r;

endmodule

// File: doc/stream_dot_product.md
Name: stream_dot_product

Overview:
- Parametrised successor to the single-lane streaming multiply-accumulate.
- Consumes LANES signed operand pairs per beat under a valid/ready handshake and accumulates a dot product over a programmable number of beats.
- Accumulation saturates at the accumulator width. The result is presented on a valid/ready output port.
- Sits between the operand stream sources (input buffers/FIFOs) and the result collector in the standalone compute datapath.

Parameters:
- DATA_W, 8, signed operand width per lane
- LANES, 4, operand pairs per beat
- ACC_W, 24, signed accumulator/result width; must be >= 2*DATA_W + $clog2(LANES), elaboration error otherwise
- LEN_W, 16, width of the beat-count configuration

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins an operation, ignored unless in IDLE
- cfg_len  in  LEN_W  number of beats; sampled on accepted start
- busy  out  1  high from accepted start until output handshake completes
- in_valid  in  1  operand beat valid
- in_ready  out  1  operand beat accepted when in_valid & in_ready
- in_a  in  LANES*DATA_W  signed lane operands; lane i at [i*DATA_W +: DATA_W]
- in_b  in  LANES*DATA_W  signed lane operands, same packing
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid & out_ready
- out_data  out  ACC_W  signed saturated dot product
- out_sat  out  1  sticky: saturation occurred at least once during this operation

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state = IDLE
  - busy, in_ready, out_valid, out_sat = 0
  - out_data = 0
  - beat counter, product registers and accumulator cleared
  - any operation in progress is abandoned with no output
- FSM states:
  - IDLE: start -> latch cfg_len, clear accumulator and out_sat, busy = 1. Next state is ACCUM if cfg_len != 0, else DONE.
  - ACCUM: in_ready = 1 while accepted beats < len. Once the last beat is accepted, in_ready = 0 and the pipeline drains, then the FSM goes to DONE.
  - DONE: out_valid = 1; out_data and out_sat held stable. On out_valid & out_ready the FSM returns to IDLE and busy = 0 on the next cycle.
- start:
  - ignored in ACCUM and DONE; it is not queued
  - start and the output handshake in the same cycle: start is ignored
- Pipeline (2 register stages):
  - Stage 1 registers LANES signed products (2*DATA_W each) plus a valid bit at the acceptance edge k.
  - Stage 2 at edge k+1 sign-extends the lane products, sums them (adder tree, width 2*DATA_W + clog2(LANES)) and performs a saturating add into the accumulator.
  - For the final beat, out_valid and out_data also update at edge k+1.
- Bubbles: in_valid low in ACCUM stalls counting with no effect on the result. Inputs are only sampled on a handshake.
- Saturation:
  - If acc + sum > 2^(ACC_W-1)-1 the accumulator clamps to that maximum; if below -2^(ACC_W-1) it clamps to -2^(ACC_W-1).
  - out_sat is set and stays set until the next start.
  - Later beats keep accumulating from the clamped value.
- cfg_len = 0: out_valid at the edge after start, out_data = 0, out_sat = 0, in_ready stays 0.
- Output backpressure: while out_ready = 0, out_valid, out_data and out_sat are held constant. No input beats are accepted.

Decomposition:
- Shared package stream_pkg holds:
  - localparam helpers: PROD_W = 2*DATA_W, SUM_W = PROD_W + $clog2(LANES)
  - state enum typedef {IDLE, ACCUM, DONE}
  - function sat_add(acc, sum) returning {sat_flag, result}
- One natural sub-module: lane_product_tree. It holds stage 1, the LANES multipliers and product registers, plus the combinational adder tree. The top level keeps the FSM, beat counter and accumulator.

Test Plan:
- LANES=4, DATA_W=8, ACC_W=24, cfg_len=3, every beat a={1,2,3,4}, b={1,1,1,1}, no bubbles -> out_data=30, out_sat=0; out_valid rises the edge after the 3rd acceptance.
- Same stimulus with in_valid deasserted for 2 cycles between every beat -> out_data=30, exactly 3 handshakes, in_ready drops after the 3rd.
- cfg_len=200, all lanes a=-128, b=-128 (65536/beat) -> saturation at beat 128; out_data=8388607, out_sat=1. Repeat with b=127 -> out_data=-8388608, out_sat=1.
- Result ready, out_ready held low 5 cycles, start pulsed twice meanwhile -> out_data stable, busy=1, starts ignored; handshake -> IDLE, busy=0 next cycle.
- cfg_len=0 start -> out_valid next cycle, out_data=0, out_sat=0, no in_ready assertion.
- cfg_len=4, reset_n pulsed low after 2 beats -> all outputs 0 immediately. Then cfg_len=1, a={2,2,2,2}, b={3,3,3,3} -> out_data=24, out_sat=0.
